ras_mt_stack: RTL and testbench

- Parametrised multi-thread return-address stack (RAS) for the fetch/pre-align stage.
- One independent circular LIFO per hardware thread: jal pushes the return address, jr pops the predicted target.
- Replaces the fixed 4-thread stack. Adds true pointers, overflow wrap, underflow detection, push+pop replace, stall hold and reset.
- Output is registered, one cycle after the request.

---
 rtl/ras_pkg.sv | 23 ++
 rtl/ras_mt_stack_if.sv | 41 ++++
 rtl/ras_thread_stack.sv | 61 ++++++
 rtl/ras_mt_stack.sv | 84 ++++++++
 tb/tb_ras_mt_stack.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ras_pkg.sv
// Shared types and width helpers for the multi-thread return-address stack.
// Build option: define RAS_FLUSH_EN to add the per-thread flush port.
package ras_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int tid_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

endpackage

// File: rtl/ras_mt_stack_if.sv
// Request/response bundle between fetch and the return-address stack.
// Build option: RAS_FLUSH_EN adds i_flush and i_flush_thread.
interface ras_mt_stack_if #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int NUM_THREADS   = 4
);
  import ras_pkg::*;

  localparam int TID_W = tid_width(NUM_THREADS);

  logic                     i_Stall;
  logic [TID_W-1:0]         i_thread;
  logic                     i_push;
  logic                     i_pop;
  logic [ADDRESS_WIDTH-1:0] i_address;
  logic [ADDRESS_WIDTH-1:0] o_address;
  logic                     o_valid;
  logic [NUM_THREADS-1:0]   o_empty;
  logic [NUM_THREADS-1:0]   o_full;
`ifdef RAS_FLUSH_EN
  logic                     i_flush;
  logic [TID_W-1:0]         i_flush_thread;
`endif

  modport master (
    output i_Stall, i_thread, i_push, i_pop, i_address,
`ifdef RAS_FLUSH_EN
    output i_flush, i_flush_thread,
`endif
    input  o_address, o_valid, o_empty, o_full
  );

  modport slave (
    input  i_Stall, i_thread, i_push, i_pop, i_address,
`ifdef RAS_FLUSH_EN
    input  i_flush, i_flush_thread,
`endif
    output o_address, o_valid, o_empty, o_full
  );

endinterface

// File: rtl/ras_thread_stack.sv
// One thread's circular LIFO: storage, top pointer and occupancy count.
// Build option: clr is driven by the RAS_FLUSH_EN flush path, else tied low.
module ras_thread_stack
  import ras_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 22,
  parameter int STACK_DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  op_e                      op,
  input  logic [ADDRESS_WIDTH-1:0] wdata,
  output logic [ADDRESS_WIDTH-1:0] rdata,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = clog2(STACK_DEPTH);
  localparam int CNT_W = clog2(STACK_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

  logic [ADDRESS_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]         tp;
  logic [PTR_W-1:0]         tp_inc;
  logic [CNT_W-1:0]         cnt;
  logic                     do_push;
  logic                     do_repl;

  assign tp_inc = tp + 1'b1;
  assign empty  = (cnt == '0);
  assign full   = (cnt == DEPTH_C);
  assign rdata  = mem[tp];

  // A replace on an empty stack degrades to a plain push.
  assign do_push = en && !clr &&
    (op == OP_PUSH || (op == OP_REPLACE && empty));
  assign do_repl = en && !clr && op == OP_REPLACE && !empty;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tp  <= '0;
      cnt <= '0;
    end else if (do_push) begin
      tp <= tp_inc;
      if (!full) cnt <= cnt + 1'b1;
    end else if (en && op == OP_POP && !empty) begin
      tp  <= tp - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push) mem[tp_inc] <= wdata;
      else if (do_repl) mem[tp] <= wdata;
    end
  end

endmodule

// File: rtl/ras_mt_stack.sv
// Multi-thread return-address stack: per-thread LIFOs, registered pop data.
// Build option: define RAS_FLUSH_EN to enable per-thread flush.
module ras_mt_stack
  import ras_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 22,
  parameter int STACK_DEPTH   = 16,
  parameter int NUM_THREADS   = 4
) (
  input logic          i_Clk,
  input logic          i_Reset,
  ras_mt_stack_if.slave bus
);

  localparam int TID_W = tid_width(NUM_THREADS);

  logic [NUM_THREADS-1:0]   req;
  logic [NUM_THREADS-1:0]   en;
  logic [NUM_THREADS-1:0]   clr;
  logic [NUM_THREADS-1:0]   empty;
  logic [NUM_THREADS-1:0]   full;
  logic [ADDRESS_WIDTH-1:0] rdata [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] sel_data;
  logic                     sel_hit;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     valid_q;
  op_e                      op;

  assign op = op_e'({bus.i_pop, bus.i_push});

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
    assign req[g] = (bus.i_thread == TID_W'(g));
`ifdef RAS_FLUSH_EN
    assign clr[g] = bus.i_flush && !bus.i_Stall &&
      (bus.i_flush_thread == TID_W'(g));
`else
    assign clr[g] = 1'b0;
`endif
    assign en[g] = req[g] && !clr[g] && !bus.i_Stall;

    ras_thread_stack #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .STACK_DEPTH  (STACK_DEPTH)
    ) u_stk (
      .clk  (i_Clk),
      .rst  (i_Reset),
      .clr  (clr[g]),
      .en   (en[g]),
      .op   (op),
      .wdata(bus.i_address),
      .rdata(rdata[g]),
      .empty(empty[g]),
      .full (full[g])
    );
  end

  // Out-of-range thread ids match no slot, so they never produce a hit.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (en[i]) begin
        sel_data = rdata[i];
        sel_hit  = bus.i_pop && !empty[i];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else if (!bus.i_Stall) begin
      valid_q <= sel_hit;
      if (sel_hit) addr_q <= sel_data;
    end
  end

  assign bus.o_address = addr_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_empty   = empty;
  assign bus.o_full    = full;

endmodule

// File: tb/tb_ras_mt_stack.sv
// Directed bench for ras_mt_stack (defaults 22/16/4).
// Build option: RAS_FLUSH_EN enables the flush steps.
module tb_ras_mt_stack;

  localparam int AW = 22;
  localparam int NT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ras_mt_stack_if #(.ADDRESS_WIDTH(AW), .NUM_THREADS(NT)) bus ();

  ras_mt_stack #(
    .ADDRESS_WIDTH(AW),
    .STACK_DEPTH  (16),
    .NUM_THREADS  (NT)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] t, input logic pu, input logic po,
                      input logic [AW-1:0] a);
    bus.i_thread  = t;
    bus.i_push    = pu;
    bus.i_pop     = po;
    bus.i_address = a;
    @(posedge clk);
    #1;
    bus.i_push = 1'b0;
    bus.i_pop  = 1'b0;
  endtask

  task automatic out(input string tag, input logic [AW-1:0] a,
                     input logic v);
    chk({tag, ".addr"}, 32'(bus.o_address), 32'(a));
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(v));
  endtask

  initial begin
    bus.i_Stall   = 1'b0;
    bus.i_thread  = '0;
    bus.i_push    = 1'b0;
    bus.i_pop     = 1'b0;
    bus.i_address = '0;
`ifdef RAS_FLUSH_EN
    bus.i_flush        = 1'b0;
    bus.i_flush_thread = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out("reset", 22'h0, 1'b0);
    chk("reset.empty", 32'(bus.o_empty), 32'hF);
    chk("reset.full", 32'(bus.o_full), 32'h0);

    step(2'd0, 1'b0, 1'b1, 22'h0);
    out("pop_empty_t0", 22'h0, 1'b0);

    step(2'd1, 1'b1, 1'b0, 22'h100);
    step(2'd1, 1'b1, 1'b0, 22'h200);
    chk("t1.empty", 32'(bus.o_empty), 32'hD);
    step(2'd1, 1'b0, 1'b1, 22'h0);
    out("t1.pop1", 22'h200, 1'b1);
    step(2'd1, 1'b0, 1'b1, 22'h0);
    out("t1.pop2", 22'h100, 1'b1);
    step(2'd1, 1'b0, 1'b1, 22'h0);
    out("t1.pop3", 22'h100, 1'b0);
    chk("t1.empty_again", 32'(bus.o_empty), 32'hF);

    for (int i = 1; i <= 16; i++) step(2'd2, 1'b1, 1'b0, AW'(i));
    chk("t2.full16", 32'(bus.o_full), 32'h4);
    step(2'd2, 1'b1, 1'b0, 22'h11);
    chk("t2.full17", 32'(bus.o_full), 32'h4);
    for (int i = 0; i < 16; i++) begin
      step(2'd2, 1'b0, 1'b1, 22'h0);
      out($sformatf("t2.pop%0d", i), AW'(32'h11 - i), 1'b1);
      if (i == 0) chk("t2.notfull", 32'(bus.o_full), 32'h0);
    end
    step(2'd2, 1'b0, 1'b1, 22'h0);
    out("t2.underflow", 22'h2, 1'b0);
    chk("t2.empty", 32'(bus.o_empty), 32'hF);

    step(2'd3, 1'b1, 1'b0, 22'h300);
    step(2'd0, 1'b1, 1'b0, 22'hA0);
    step(2'd3, 1'b1, 1'b1, 22'h3AA);
    out("t3.replace", 22'h300, 1'b1);
    chk("t3.empty_vec", 32'(bus.o_empty), 32'h6);
    step(2'd3, 1'b0, 1'b1, 22'h0);
    out("t3.pop_new", 22'h3AA, 1'b1);
    step(2'd3, 1'b0, 1'b1, 22'h0);
    out("t3.pop_empty", 22'h3AA, 1'b0);
    step(2'd0, 1'b0, 1'b1, 22'h0);
    out("t0.untouched", 22'hA0, 1'b1);

    step(2'd1, 1'b1, 1'b1, 22'h55);
    out("t1.repl_empty", 22'hA0, 1'b0);
    step(2'd1, 1'b0, 1'b1, 22'h0);
    out("t1.pop_repl", 22'h55, 1'b1);

    step(2'd0, 1'b1, 1'b0, 22'h10);
    step(2'd0, 1'b1, 1'b0, 22'h20);
    step(2'd0, 1'b0, 1'b1, 22'h0);
    out("t0.pre_stall", 22'h20, 1'b1);
    bus.i_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 1'b1, 1'b0, 22'h40);
      out($sformatf("stall%0d", i), 22'h20, 1'b1);
    end
    bus.i_Stall = 1'b0;
    step(2'd0, 1'b0, 1'b1, 22'h0);
    out("t0.post_stall", 22'h10, 1'b1);
    chk("t0.empty_post", 32'(bus.o_empty), 32'hF);
    step(2'd0, 1'b0, 1'b0, 22'h0);
    out("idle", 22'h10, 1'b0);

    step(2'd1, 1'b1, 1'b0, 22'h77);
    step(2'd2, 1'b1, 1'b0, 22'h88);
    step(2'd1, 1'b0, 1'b1, 22'h0);
    out("t1.pre_rst", 22'h77, 1'b1);
    rst = 1'b1;
    step(2'd2, 1'b0, 1'b1, 22'h0);
    rst = 1'b0;
    out("mid_rst", 22'h0, 1'b0);
    chk("mid_rst.empty", 32'(bus.o_empty), 32'hF);
    step(2'd2, 1'b0, 1'b1, 22'h0);
    out("t2.after_rst", 22'h0, 1'b0);

`ifdef RAS_FLUSH_EN
    step(2'd1, 1'b1, 1'b0, 22'h111);
    step(2'd1, 1'b1, 1'b0, 22'h122);
    step(2'd0, 1'b1, 1'b0, 22'hB0);
    bus.i_flush        = 1'b1;
    bus.i_flush_thread = 2'd1;
    step(2'd0, 1'b0, 1'b1, 22'h0);
    bus.i_flush = 1'b0;
    out("fl.t0_pop", 22'hB0, 1'b1);
    chk("fl.empty", 32'(bus.o_empty), 32'hF);
    step(2'd1, 1'b0, 1'b1, 22'h0);
    out("fl.t1_pop", 22'hB0, 1'b0);
    step(2'd2, 1'b1, 1'b0, 22'hC0);
    bus.i_flush        = 1'b1;
    bus.i_flush_thread = 2'd2;
    step(2'd2, 1'b0, 1'b1, 22'h0);
    bus.i_flush = 1'b0;
    out("fl.same_thr", 22'hB0, 1'b0);
    chk("fl.same_empty", 32'(bus.o_empty), 32'hF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
